// File: rtl/mult_div_unit.sv
// mult_div_unit -- HI/LO multiply/divide unit for a pipelined MIPS-style core.
//
// Multiply and divide results are computed combinationally from operands
// latched at issue. A countdown (5 for multiply, 10 for divide) times the
// write-back, so busy is high for exactly that many cycles and hi/lo are
// written on the edge that clears busy. mthi/mtlo write hi/lo directly when
// the unit is idle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   md_valid  in   EX-stage instruction valid and not flushed
//   md_func   in   [2:0] 0 none, 1 mthi, 2 mtlo, 3 multiply, 4 divide, 5..7 none
//   md_sign   in   1 = signed (mult/div), 0 = unsigned (multu/divu)
//   op_a      in   [31:0] rs: multiplicand / dividend / mthi-mtlo source
//   op_b      in   [31:0] rt: multiplier / divisor
//   hi        out  [31:0] registered HI
//   lo        out  [31:0] registered LO
//   busy      out  registered; high while a multiply or divide is in flight
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_func,
  input  logic        md_sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [2:0] FUNC_MTHI   = 3'd1;
  localparam logic [2:0] FUNC_MTLO   = 3'd2;
  localparam logic [2:0] FUNC_MULT   = 3'd3;
  localparam logic [2:0] FUNC_DIV    = 3'd4;
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_q, sign_d;
  logic        op_div_q, op_div_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        issue_s;
  logic        done_s;
  logic [63:0] ext_a_s, ext_b_s, product_s;
  logic        neg_a_s, neg_b_s;
  logic [31:0] abs_a_s, abs_b_s, divisor_s;
  logic [31:0] uquot_s, urem_s, quot_s, rem_s;

  // Issue is only possible from idle, so anything presented while busy is dropped.
  assign issue_s = md_valid && (state_q == ST_IDLE) &&
                   ((md_func == FUNC_MULT) || (md_func == FUNC_DIV));
  // The edge that sees a count of one is the N-th edge after issue.
  assign done_s  = (state_q == ST_BUSY) && (cnt_q == 4'd1);

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == ST_BUSY);

  // Result datapath from the latched operands; only sampled on the done edge.
  always_comb begin
    // Sign-extend only for signed ops; the low 64 bits of the product are then exact.
    ext_a_s   = {{32{sign_q & a_q[31]}}, a_q};
    ext_b_s   = {{32{sign_q & b_q[31]}}, b_q};
    product_s = ext_a_s * ext_b_s;
    neg_a_s   = sign_q & a_q[31];
    neg_b_s   = sign_q & b_q[31];
    abs_a_s   = neg_a_s ? (32'd0 - a_q) : a_q;
    abs_b_s   = neg_b_s ? (32'd0 - b_q) : b_q;
    // Dummy divisor keeps the divider well defined; the zero case is never written.
    divisor_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
    uquot_s   = abs_a_s / divisor_s;
    urem_s    = abs_a_s % divisor_s;
    // 0x80000000 / -1 wraps back to 0x80000000 through this negate.
    quot_s    = (neg_a_s ^ neg_b_s) ? (32'd0 - uquot_s) : uquot_s;
    rem_s     = neg_a_s ? (32'd0 - urem_s) : urem_s;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      op_div_q <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      op_div_q <= op_div_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state logic for the idle/busy controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state register updates: operand capture, countdown, hi/lo writes.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    op_div_d = op_div_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_valid) begin
          case (md_func)
            FUNC_MTHI: hi_d = op_a;
            FUNC_MTLO: lo_d = op_a;
            FUNC_MULT: begin
              a_d      = op_a;
              b_d      = op_b;
              sign_d   = md_sign;
              op_div_d = 1'b0;
              cnt_d    = MULT_CYCLES;
            end
            FUNC_DIV: begin
              a_d      = op_a;
              b_d      = op_b;
              sign_d   = md_sign;
              op_div_d = 1'b1;
              cnt_d    = DIV_CYCLES;
            end
            default: cnt_d = cnt_q;
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (done_s) begin
          if (!op_div_q) begin
            hi_d = product_s[63:32];
            lo_d = product_s[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end else begin
            // Divide by zero: timing is kept but hi/lo are left alone.
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        md_valid;
  logic [2:0]  md_func;
  logic        md_sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .md_valid (md_valid),
    .md_func  (md_func),
    .md_sign  (md_sign),
    .op_a     (op_a),
    .op_b     (op_b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  func;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op at the current negedge, let one edge take it, then count
  // busy cycles (sampled at negedges) and watch hi/lo stay put meanwhile.
  task automatic run_op(input vec_t v, output int cycles, output bit stable);
    logic [31:0] pre_hi, pre_lo;
    pre_hi   = hi;
    pre_lo   = lo;
    md_valid = v.valid;
    md_func  = v.func;
    md_sign  = v.sign;
    op_a     = v.a;
    op_b     = v.b;
    @(posedge clk);
    @(negedge clk);
    md_valid = 1'b0;
    md_func  = 3'd0;
    cycles   = 0;
    stable   = 1'b1;
    while (busy && cycles < 20) begin
      cycles++;
      if (hi !== pre_hi || lo !== pre_lo) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int  cycles;
    bit  stable;
    bit  busy_seen;
    vec_t v;

    vecs[0]  = '{1'b1, 3'd1, 1'b0, 32'h00000011, 32'h0,        32'h00000011, 32'h00000000, 0};
    vecs[1]  = '{1'b1, 3'd2, 1'b0, 32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0};
    vecs[2]  = '{1'b1, 3'd4, 1'b0, 32'h00000007, 32'h0,        32'h00000011, 32'h00000022, 10};
    vecs[3]  = '{1'b1, 3'd3, 1'b1, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[4]  = '{1'b1, 3'd3, 1'b0, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[5]  = '{1'b1, 3'd4, 1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[6]  = '{1'b1, 3'd4, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[7]  = '{1'b1, 3'd4, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[8]  = '{1'b1, 3'd4, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{1'b1, 3'd3, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[10] = '{1'b1, 3'd3, 1'b0, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
    vecs[11] = '{1'b1, 3'd4, 1'b0, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[12] = '{1'b1, 3'd5, 1'b0, 32'h0000DEAD, 32'h1,        32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[13] = '{1'b0, 3'd3, 1'b0, 32'h00000005, 32'h5,        32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[14] = '{1'b1, 3'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[15] = '{1'b0, 3'd1, 1'b0, 32'h0000BEEF, 32'h0,        32'h00000000, 32'h00000001, 0};
    vecs[16] = '{1'b1, 3'd4, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 10};
    vecs[17] = '{1'b1, 3'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[18] = '{1'b1, 3'd4, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
    vecs[19] = '{1'b1, 3'd7, 1'b1, 32'h12345678, 32'h1,        32'hFFFFFFFF, 32'h00000003, 0};
    vecs[20] = '{1'b1, 3'd4, 1'b0, 32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC, 10};

    reset    = 1'b0;
    md_valid = 1'b0;
    md_func  = 3'd0;
    md_sign  = 1'b0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;

    // Table-driven vectors, each issued at the first edge after the previous one finished.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], cycles, stable);
      check($sformatf("v%0d_cycles", i), cycles, vecs[i].exp_cycles);
      check($sformatf("v%0d_stable", i), {31'd0, stable}, 32'd1);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Ignore while busy: mthi and a new divide during a multiply, operands wiggled too.
    md_valid = 1'b1; md_func = 3'd3; md_sign = 1'b1;
    op_a = 32'hFFFFFFFD; op_b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      if (cycles == 1) begin
        md_valid = 1'b1; md_func = 3'd1; op_a = 32'h0000ABCD;
      end else if (cycles == 2) begin
        md_func = 3'd4; md_sign = 1'b0; op_a = 32'd100; op_b = 32'd3;
      end else if (cycles == 3) begin
        md_func = 3'd2; op_b = 32'd0;
      end else begin
        md_valid = 1'b0; md_func = 3'd0;
      end
      @(negedge clk);
    end
    check("ign_cycles", cycles, 32'd5);
    check("ign_hi", hi, 32'hFFFFFFFF);
    check("ign_lo", lo, 32'hFFFFFFF4);
    busy_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("ign_busy_after", {31'd0, busy_seen}, 32'd0);
    check("ign_hi_after", hi, 32'hFFFFFFFF);

    // Reset in the middle of a divide.
    md_valid = 1'b1; md_func = 3'd4; md_sign = 1'b0;
    op_a = 32'd100; op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // First edge after release must accept an issue, with no stale divide write.
    v = '{1'b1, 3'd3, 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 5};
    run_op(v, cycles, stable);
    check("post_rst_cycles", cycles, 32'd5);
    check("post_rst_stable", {31'd0, stable}, 32'd1);
    check("post_rst_hi", hi, 32'h0);
    check("post_rst_lo", lo, 32'd42);
    busy_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("post_rst_busy_idle", {31'd0, busy_seen}, 32'd0);
    check("post_rst_hi_idle", hi, 32'h0);
    check("post_rst_lo_idle", lo, 32'd42);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
